// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - next-PC unit: PC register, jump resolve, delay slot, stall, exception entry/return
//
// Build option: define PC_UNIT_RAS_EN to add a circular return-address stack
// (jump_control 111 = RET, call_push pushes a link on a taken JUMP/DB).
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-low reset
//   stall        hold PC, state, pending target and stack
//   jump_control 000 IDLE, 001 EQZ, 010 NEZ, 011 TEQZ, 100 TNEZ, 101 JUMP, 110 DB, 111 RET
//   branch_pc    PC of the instruction being resolved
//   offset       branch offset, sign-extended then shifted by OFF_SHIFT
//   rs           register operand (zero test / jump target)
//   t            T flag
//   call_push    push link address on a taken JUMP/DB (stack builds only)
//   exc_req      exception request
//   exc_ack      one-cycle acknowledge, registered
//   eret         return from exception
//   pc           current fetch PC, registered
//   taken        redirect accepted this cycle, combinational
//   epc          saved exception return PC
//   slot_busy    high while the delay slot is being fetched
module pc_unit #(
    parameter int                WIDTH       = 16,
    parameter int                OFF_W       = 8,
    parameter int                OFF_SHIFT   = 0,
    parameter int                INC         = 2,
    parameter logic [WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR  = WIDTH'(16'h0008),
    parameter int                DELAY_SLOTS = 0,
    parameter int                RAS_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       jump_control,
    input  logic [WIDTH-1:0] branch_pc,
    input  logic [OFF_W-1:0] offset,
    input  logic [WIDTH-1:0] rs,
    input  logic             t,
    input  logic             call_push,
    input  logic             exc_req,
    output logic             exc_ack,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic             taken,
    output logic [WIDTH-1:0] epc,
    output logic             slot_busy
);

    typedef enum logic {SEQ = 1'b0, SLOT = 1'b1} state_t;

    localparam logic [2:0] JC_EQZ  = 3'b001;
    localparam logic [2:0] JC_NEZ  = 3'b010;
    localparam logic [2:0] JC_TEQZ = 3'b011;
    localparam logic [2:0] JC_TNEZ = 3'b100;
    localparam logic [2:0] JC_JUMP = 3'b101;
    localparam logic [2:0] JC_DB   = 3'b110;
    localparam logic [2:0] JC_RET  = 3'b111;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] pend_q;
    logic             exc_ack_q;
    logic             exc_block_q;   // set once a request is taken, cleared when exc_req drops

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] tgt;
    logic             cond;
    logic             exc_accept;

    assign pc_inc     = pc_q + WIDTH'(INC);
    assign off_ext    = {{(WIDTH-OFF_W){offset[OFF_W-1]}}, offset};
    assign br_tgt     = branch_pc + (off_ext << OFF_SHIFT);
    assign exc_accept = exc_req && !exc_block_q;

`ifdef PC_UNIT_RAS_EN
    localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0]  ras_q [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_top_q;
    logic [RAS_CW-1:0] ras_cnt_q;
    logic [RAS_AW-1:0] ras_top_inc;
    logic [RAS_AW-1:0] ras_top_dec;
    logic              ras_push;
    logic              ras_pop;

    assign ras_top_inc = (ras_top_q == RAS_AW'(RAS_DEPTH - 1)) ? '0 : ras_top_q + 1'b1;
    assign ras_top_dec = (ras_top_q == '0) ? RAS_AW'(RAS_DEPTH - 1) : ras_top_q - 1'b1;
    // eret outranks the jump, so a taken RET/call under eret must not touch the stack
    assign ras_push = taken && !eret && call_push &&
                      ((jump_control == JC_JUMP) || (jump_control == JC_DB));
    assign ras_pop  = taken && !eret && (jump_control == JC_RET) && (ras_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_top_q <= '0;
            ras_cnt_q <= '0;
        end else if (ras_push) begin
            ras_top_q <= ras_top_inc;
            // a full stack silently overwrites its oldest slot
            if (ras_cnt_q != RAS_CW'(RAS_DEPTH)) begin
                ras_cnt_q <= ras_cnt_q + 1'b1;
            end
        end else if (ras_pop) begin
            ras_top_q <= ras_top_dec;
            ras_cnt_q <= ras_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && ras_push) begin
            ras_q[ras_top_inc] <= branch_pc + WIDTH'(INC * (1 + DELAY_SLOTS));
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_call_push;
    assign unused_call_push = call_push;
`endif

    always_comb begin
        cond = 1'b0;
        tgt  = br_tgt;
        case (jump_control)
            JC_EQZ:  cond = (rs == '0);
            JC_NEZ:  cond = (rs != '0);
            JC_TEQZ: cond = !t;
            JC_TNEZ: cond = t;
            JC_JUMP: begin
                cond = 1'b1;
                tgt  = rs;
            end
            JC_DB:   cond = 1'b1;
`ifdef PC_UNIT_RAS_EN
            JC_RET:  begin
                cond = 1'b1;
                tgt  = (ras_cnt_q != '0) ? ras_q[ras_top_q] : rs;
            end
`endif
            default: cond = 1'b0;
        endcase
    end

    assign taken = (state_q == SEQ) && !stall && !exc_req && cond;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SEQ;
            pc_q        <= RESET_PC;
            epc_q       <= '0;
            pend_q      <= '0;
            exc_ack_q   <= 1'b0;
            exc_block_q <= 1'b0;
        end else begin
            exc_ack_q <= 1'b0;
            if (exc_accept) begin
                // return address is whatever would have been fetched next
                epc_q       <= (state_q == SLOT) ? pend_q : pc_inc;
                pc_q        <= EXC_VECTOR;
                state_q     <= SEQ;
                pend_q      <= '0;
                exc_ack_q   <= 1'b1;
                exc_block_q <= 1'b1;
            end else begin
                if (!exc_req) begin
                    exc_block_q <= 1'b0;
                end
                if (eret) begin
                    pc_q    <= epc_q;
                    state_q <= SEQ;
                end else if (!stall) begin
                    if (state_q == SLOT) begin
                        pc_q    <= pend_q;
                        state_q <= SEQ;
                    end else if (taken) begin
                        if (DELAY_SLOTS == 0) begin
                            pc_q <= tgt;
                        end else begin
                            pc_q    <= pc_inc;
                            pend_q  <= tgt;
                            state_q <= SLOT;
                        end
                    end else begin
                        pc_q <= pc_inc;
                    end
                end
            end
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign exc_ack   = exc_ack_q;
    assign slot_busy = (state_q == SLOT);

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit, immediate and delay-slot builds side by side
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    localparam int RAS_D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  jc = 3'd0;
    logic [15:0] bpc = 16'd0;
    logic [7:0]  off = 8'd0;
    logic [15:0] rs = 16'd0;
    logic        t = 1'b0;
    logic        cp = 1'b0;
    logic        exc = 1'b0;
    logic        eret = 1'b0;

    logic        ack0, ack1, tk0, tk1, sb0, sb1;
    logic [15:0] pc0, pc1, epc0, epc1;

    always #5 clk = ~clk;

    pc_unit #(.DELAY_SLOTS(0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .jump_control(jc), .branch_pc(bpc),
        .offset(off), .rs(rs), .t(t), .call_push(cp), .exc_req(exc), .exc_ack(ack0),
        .eret(eret), .pc(pc0), .taken(tk0), .epc(epc0), .slot_busy(sb0)
    );

    pc_unit #(.DELAY_SLOTS(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .jump_control(jc), .branch_pc(bpc),
        .offset(off), .rs(rs), .t(t), .call_push(cp), .exc_req(exc), .exc_ack(ack1),
        .eret(eret), .pc(pc1), .taken(tk1), .epc(epc1), .slot_busy(sb1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // staged stimulus for the next cycle
    logic        s_rst, s_stall, s_t, s_cp, s_exc, s_eret;
    logic [2:0]  s_jc;
    logic [15:0] s_bpc, s_rs;
    logic [7:0]  s_off;

    // reference model: index 0 = immediate redirect, 1 = one delay slot
    logic [15:0] m_pc [2];
    logic [15:0] m_epc [2];
    logic [15:0] m_pend [2];
    logic        m_slot [2];
    logic        m_ack [2];
    logic        m_block [2];
    logic [15:0] ras0 [$];
    logic [15:0] ras1 [$];

    function automatic int ras_size(input int d);
        return (d == 0) ? ras0.size() : ras1.size();
    endfunction

    function automatic logic [15:0] ras_top(input int d);
        if (ras_size(d) == 0) return 16'd0;
        return (d == 0) ? ras0[$] : ras1[$];
    endfunction

    task automatic ras_push(input int d, input logic [15:0] v);
        if (d == 0) begin
            ras0.push_back(v);
            if (ras0.size() > RAS_D) void'(ras0.pop_front());
        end else begin
            ras1.push_back(v);
            if (ras1.size() > RAS_D) void'(ras1.pop_front());
        end
    endtask

    task automatic ras_pop(input int d);
        if (d == 0) void'(ras0.pop_back());
        else        void'(ras1.pop_back());
    endtask

    task automatic model_step(input int d, output logic tk);
        logic        cond;
        logic [15:0] tgt;
        logic [15:0] sext;
        int          n;
        n    = ras_size(d);
        sext = {{8{s_off[7]}}, s_off};
        case (s_jc)
            3'd1:       cond = (s_rs == 16'd0);
            3'd2:       cond = (s_rs != 16'd0);
            3'd3:       cond = !s_t;
            3'd4:       cond = s_t;
            3'd5, 3'd6: cond = 1'b1;
            default:    cond = RAS && (s_jc == 3'd7);
        endcase
        if (s_jc == 3'd5)      tgt = s_rs;
        else if (s_jc == 3'd7) tgt = (n > 0) ? ras_top(d) : s_rs;
        else                   tgt = s_bpc + sext;
        tk = !m_slot[d] && !s_stall && !s_exc && cond;

        if (!s_rst) begin
            m_pc[d] = 16'd0; m_epc[d] = 16'd0; m_pend[d] = 16'd0;
            m_slot[d] = 1'b0; m_ack[d] = 1'b0; m_block[d] = 1'b0;
            if (d == 0) ras0.delete(); else ras1.delete();
        end else if (s_exc && !m_block[d]) begin
            m_epc[d]   = m_slot[d] ? m_pend[d] : 16'(m_pc[d] + 16'd2);
            m_pc[d]    = 16'h0008;
            m_slot[d]  = 1'b0;
            m_block[d] = 1'b1;
            m_ack[d]   = 1'b1;
        end else begin
            m_ack[d] = 1'b0;
            if (!s_exc) m_block[d] = 1'b0;
            if (s_eret) begin
                m_pc[d]   = m_epc[d];
                m_slot[d] = 1'b0;
            end else if (s_stall) begin
                m_pc[d] = m_pc[d];
            end else if (m_slot[d]) begin
                m_pc[d]   = m_pend[d];
                m_slot[d] = 1'b0;
            end else if (tk) begin
                if (RAS && s_cp && (s_jc == 3'd5 || s_jc == 3'd6))
                    ras_push(d, 16'(s_bpc + 16'(2 * (1 + d))));
                if (RAS && s_jc == 3'd7 && n > 0) ras_pop(d);
                if (d == 0) begin
                    m_pc[d] = tgt;
                end else begin
                    m_pc[d]   = m_pc[d] + 16'd2;
                    m_pend[d] = tgt;
                    m_slot[d] = 1'b1;
                end
            end else begin
                m_pc[d] = m_pc[d] + 16'd2;
            end
        end
    endtask

    typedef struct {
        logic        t0, t1, sb0, sb1, ak0, ak1;
        logic [15:0] pc0, pc1, epc0, epc1;
    } exp_t;

    exp_t sb_q [$];

    // drive one cycle of stimulus and queue what both units must show
    task automatic issue();
        exp_t e;
        logic k0, k1;
        @(negedge clk);
        rst = s_rst; stall = s_stall; jc = s_jc; bpc = s_bpc; off = s_off;
        rs = s_rs; t = s_t; cp = s_cp; exc = s_exc; eret = s_eret;
        model_step(0, k0);
        model_step(1, k1);
        e.t0 = k0; e.t1 = k1;
        e.pc0 = m_pc[0]; e.pc1 = m_pc[1]; e.epc0 = m_epc[0]; e.epc1 = m_epc[1];
        e.sb0 = m_slot[0]; e.sb1 = m_slot[1]; e.ak0 = m_ack[0]; e.ak1 = m_ack[1];
        sb_q.push_back(e);
    endtask

    task automatic idle_defaults();
        s_rst = 1'b1; s_stall = 1'b0; s_jc = 3'd0; s_bpc = 16'd0; s_off = 8'd0;
        s_rs = 16'd0; s_t = 1'b0; s_cp = 1'b0; s_exc = 1'b0; s_eret = 1'b0;
    endtask

    task automatic idle_n(input int n);
        idle_defaults();
        for (int i = 0; i < n; i++) issue();
    endtask

    task automatic do_reset();
        idle_defaults();
        s_rst = 1'b0;
        issue();
        idle_defaults();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // monitor: taken before the edge, registered state after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("taken0", tk0, e.t0);
                chk("taken1", tk1, e.t1);
                @(posedge clk);
                #1;
                chk("pc0", pc0, e.pc0);
                chk("pc1", pc1, e.pc1);
                chk("epc0", epc0, e.epc0);
                chk("epc1", epc1, e.epc1);
                chk("slot0", sb0, e.sb0);
                chk("slot1", sb1, e.sb1);
                chk("ack0", ack0, e.ak0);
                chk("ack1", ack1, e.ak1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held two clocks, then sequential fetch
        idle_defaults();
        s_rst = 1'b0;
        issue();
        issue();
        after_edge();
        chk("rst_pc", pc0, 16'h0000);
        chk("rst_ack", ack0, 1'b0);
        idle_defaults();
        for (int i = 1; i <= 3; i++) begin
            issue();
            after_edge();
            chk("seq_pc", pc0, 16'(2 * i));
        end

        // EQZ taken / not taken
        do_reset();
        idle_n(8);
        s_jc = 3'd1; s_bpc = 16'h0010; s_off = 8'hFC; s_rs = 16'd0;
        issue();
        #1 chk("eqz_taken", tk0, 1'b1);
        after_edge();
        chk("eqz_pc0", pc0, 16'h000C);
        chk("eqz_pc1", pc1, 16'h0012);
        do_reset();
        idle_n(8);
        s_jc = 3'd1; s_bpc = 16'h0010; s_off = 8'hFC; s_rs = 16'd5;
        issue();
        #1 chk("eqz_nt", tk0, 1'b0);
        after_edge();
        chk("eqz_nt_pc", pc0, 16'h0012);

        // delay slot, DB in the slot ignored
        do_reset();
        idle_n(16);
        s_jc = 3'd5; s_rs = 16'h0100;
        issue();
        after_edge();
        chk("ds_pc1", pc1, 16'h0022);
        chk("ds_busy", sb1, 1'b1);
        idle_defaults();
        s_jc = 3'd6; s_bpc = 16'h0022; s_off = 8'h10;
        issue();
        #1 chk("ds_db_ign", tk1, 1'b0);
        after_edge();
        chk("ds_tgt", pc1, 16'h0100);
        chk("ds_pc0", pc0, 16'h0032);

        // stall freezes everything
        idle_defaults();
        s_stall = 1'b1; s_jc = 3'd2; s_rs = 16'd1; s_bpc = 16'h0040; s_off = 8'h04;
        for (int i = 0; i < 3; i++) begin
            issue();
            #1 chk("stall_tk", tk0, 1'b0);
            after_edge();
            chk("stall_pc0", pc0, 16'h0032);
            chk("stall_pc1", pc1, 16'h0100);
        end
        s_stall = 1'b0;
        issue();
        after_edge();
        chk("unstall_pc0", pc0, 16'h0044);

        // exception in the slot, held request, eret
        do_reset();
        idle_n(16);
        s_jc = 3'd5; s_rs = 16'h0100;
        issue();
        idle_defaults();
        s_exc = 1'b1;
        issue();
        after_edge();
        chk("exc_pc", pc1, 16'h0008);
        chk("exc_epc1", epc1, 16'h0100);
        chk("exc_epc0", epc0, 16'h0102);
        chk("exc_ack", ack1, 1'b1);
        issue();
        after_edge();
        chk("exc_ack_once", ack1, 1'b0);
        chk("exc_held_pc", pc1, 16'h000A);
        idle_n(1);
        s_eret = 1'b1;
        issue();
        after_edge();
        chk("eret_pc1", pc1, 16'h0100);
        chk("eret_pc0", pc0, 16'h0102);

        // wrap at the top of the address space
        idle_defaults();
        s_jc = 3'd5; s_rs = 16'hFFFE;
        issue();
        after_edge();
        chk("wrap_top", pc0, 16'hFFFE);
        idle_n(1);
        after_edge();
        chk("wrap_pc", pc0, 16'h0000);

`ifdef PC_UNIT_RAS_EN
        // five calls into a four-deep stack, then five returns
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            idle_defaults();
            s_jc = 3'd5; s_cp = 1'b1; s_bpc = 16'(16'h0100 * k); s_rs = 16'(16'h1000 * k);
            issue();
            idle_n(1);
        end
        for (int k = 0; k < 5; k++) begin
            idle_defaults();
            s_jc = 3'd7; s_rs = 16'h0ABC;
            issue();
            after_edge();
            chk("ret_pc0", pc0, (k < 4) ? 16'(16'h0100 * (5 - k) + 16'd2) : 16'h0ABC);
            idle_n(1);
        end
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s_rst   = ($urandom_range(0, 99) != 0);
            s_stall = ($urandom_range(0, 4) == 0);
            s_jc    = 3'($urandom_range(0, 7));
            s_bpc   = 16'($urandom);
            s_off   = 8'($urandom);
            s_rs    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            s_t     = 1'($urandom);
            s_cp    = 1'($urandom);
            s_exc   = ($urandom_range(0, 15) == 0);
            s_eret  = ($urandom_range(0, 19) == 0);
            issue();
        end

        idle_defaults();
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
